// File: rtl/fu_pkg.sv
// Shared types for the functional-unit issue path.
package fu_pkg;

    localparam int unsigned FU_DW = 8;

    typedef logic [2:0] fu_op_t;

    typedef struct packed {
        fu_op_t             instruction;
        logic [FU_DW-1:0]   A;
        logic [FU_DW-1:0]   B;
    } fu_triple_t;

endpackage

// File: rtl/fu_sync_fifo.sv
// Synchronous FIFO of fu_triple_t entries with occupancy count.
// Caller guarantees no push when full and no pop when empty.
module fu_sync_fifo
    import fu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  fu_triple_t      i_wdata,
    input  logic            i_pop,
    output fu_triple_t      o_rdata,
    output logic [CW-1:0]   o_count,
    output logic            o_empty,
    output logic            o_full
);

    localparam int unsigned PW = $clog2(DEPTH);

    fu_triple_t         r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    // Storage array; no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Occupancy: unchanged on simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/fu_issue_queue.sv
// Operand-issue stage in front of the combinational Functional_Unit:
// FIFO -> S1 (issue register driving fu_*) -> S2 (result register).
// Optional completed-result counter enabled by FU_ISSUE_OPCNT_EN.
module fu_issue_queue
    import fu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_instruction,
    input  logic [7:0]      in_A,
    input  logic [7:0]      in_B,
    output logic [2:0]      fu_instruction,
    output logic [7:0]      fu_A,
    output logic [7:0]      fu_B,
    input  logic [7:0]      fu_F,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_F,
    output logic [2:0]      out_instruction,
    output logic [CW-1:0]   count,
    output logic [15:0]     op_count
);

    fu_triple_t         w_wdata;
    fu_triple_t         w_head;
    logic [CW-1:0]      w_count;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_s1_adv;
    logic               w_s1_load;

    logic               r_s1_valid;
    fu_triple_t         r_s1;
    logic               r_s2_valid;
    logic [FU_DW-1:0]   r_s2_f;
    fu_op_t             r_s2_instr;

    assign w_wdata = '{instruction: in_instruction, A: in_A, B: in_B};

    // No pop-to-push bypass: a full FIFO refuses even while popping.
    assign in_ready  = !w_full;
    assign w_push    = in_valid && in_ready;
    assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_s1_load = !w_empty && (!r_s1_valid || w_s1_adv);

    fu_sync_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_s1_load),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // S1 issue register; payload holds its last value when S1 empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1       <= w_head;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 result register; fu_F is sampled only when S1 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_f     <= '0;
            r_s2_instr <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_f     <= fu_F;
            r_s2_instr <= r_s1.instruction;
        end else if (r_s2_valid && out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

`ifdef FU_ISSUE_OPCNT_EN
    logic [15:0] r_op_count;

    // Completed-result counter, wraps at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`else
    assign op_count = 16'h0000;
`endif

    assign fu_instruction  = r_s1.instruction;
    assign fu_A            = r_s1.A;
    assign fu_B            = r_s1.B;
    assign out_valid       = r_s2_valid;
    assign out_F           = r_s2_f;
    assign out_instruction = r_s2_instr;
    assign count           = w_count;

endmodule

// File: tb/tb_fu_issue_queue.sv
// Bench for fu_issue_queue: directed scenarios plus random traffic,
// compared against a queue-based pipeline model and a push-order scoreboard.
module tb_fu_issue_queue;
    import fu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     in_instruction = '0;
    logic [7:0]     in_A = '0;
    logic [7:0]     in_B = '0;
    logic [2:0]     fu_instruction;
    logic [7:0]     fu_A;
    logic [7:0]     fu_B;
    logic [7:0]     fu_F;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [7:0]     out_F;
    logic [2:0]     out_instruction;
    logic [CW-1:0]  count;
    logic [15:0]    op_count;

    // Functional unit stub.
    assign fu_F = fu_A ^ fu_B;

    always #5 clk = ~clk;

    fu_issue_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_A            (in_A),
        .in_B            (in_B),
        .fu_instruction  (fu_instruction),
        .fu_A            (fu_A),
        .fu_B            (fu_B),
        .fu_F            (fu_F),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_F           (out_F),
        .out_instruction (out_instruction),
        .count           (count),
        .op_count        (op_count)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct packed {
        logic [2:0] ins;
        logic [7:0] f;
    } res_t;

    // Model: FIFO contents, S1 slot, S2 slot, and expected results in push order.
    fu_triple_t     m_q[$];
    logic           m_s1v;
    fu_triple_t     m_s1;
    logic           m_s2v;
    logic [7:0]     m_s2f;
    logic [2:0]     m_s2i;
    logic [15:0]    m_opcnt;
    res_t           exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_s1v   = 1'b0;
        m_s1    = '0;
        m_s2v   = 1'b0;
        m_s2f   = '0;
        m_s2i   = '0;
        m_opcnt = '0;
    endtask

    function automatic logic [15:0] exp_opcnt();
`ifdef FU_ISSUE_OPCNT_EN
        return m_opcnt;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_state();
        check("count", count, m_q.size());
        check("in_ready", in_ready, (m_q.size() < DEPTH) ? 1 : 0);
        check("out_valid", out_valid, m_s2v);
        check("out_F", out_F, m_s2f);
        check("out_instr", out_instruction, m_s2i);
        check("fu_instr", fu_instruction, m_s1.instruction);
        check("fu_A", fu_A, m_s1.A);
        check("fu_B", fu_B, m_s1.B);
        check("op_count", op_count, exp_opcnt());
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [2:0] ins, input logic [7:0] a,
                         input logic [7:0] b, input logic ordy);
        fu_triple_t t;
        res_t       r;
        logic       push, adv, hand, load;
        check_state();
        in_valid       = v;
        in_instruction = ins;
        in_A           = a;
        in_B           = b;
        out_ready      = ordy;
        push = v && (m_q.size() < DEPTH);
        adv  = m_s1v && (!m_s2v || ordy);
        hand = m_s2v && ordy;
        load = (m_q.size() != 0) && (!m_s1v || adv);
        if (hand) begin
            if (exp_q.size() == 0) begin
                check("order_underflow", 1, 0);
            end else begin
                r = exp_q.pop_front();
                check("order_F", out_F, r.f);
                check("order_instr", out_instruction, r.ins);
            end
            m_opcnt = m_opcnt + 16'd1;
        end
        @(posedge clk);
        if (adv) begin
            m_s2v = 1'b1;
            m_s2f = m_s1.A ^ m_s1.B;
            m_s2i = m_s1.instruction;
        end else if (hand) begin
            m_s2v = 1'b0;
        end
        if (load) begin
            m_s1  = m_q.pop_front();
            m_s1v = 1'b1;
        end else if (adv) begin
            m_s1v = 1'b0;
        end
        if (push) begin
            t.instruction = ins;
            t.A           = a;
            t.B           = b;
            m_q.push_back(t);
            r.ins = ins;
            r.f   = a ^ b;
            exp_q.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fu_A", fu_A, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
    endtask

    logic [7:0] ta [20];
    logic [7:0] tb [20];

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single op latency.
        cycle(1'b1, 3'b010, 8'h3C, 8'h0F, 1'b1);
        cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        check("single_fuA", fu_A, 8'h3C);
        cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        check("single_valid", out_valid, 1);
        check("single_F", out_F, 8'h33);
        check("single_ins", out_instruction, 3'b010);
        cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);

        // Reset with work in flight: 1 in S2, 1 in S1, 3 queued.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end
        check("pre_rst_count", count, 3);
        do_reset();

        // Full back-pressure.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'(i), 8'(i), 8'hFF, 1'b0);
        end
        check("bp_count", count, 4);
        check("bp_in_ready", in_ready, 0);
        cycle(1'b1, 3'd7, 8'h77, 8'hFF, 1'b0);
        check("bp_refused", count, 4);

        // Drain in order on consecutive cycles.
        for (int j = 0; j < 6; j++) begin
            check("drain_valid", out_valid, 1);
            check("drain_F", out_F, 8'(8'hFF - j));
            cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        end
        check("drain_empty", out_valid, 0);
`ifdef FU_ISSUE_OPCNT_EN
        check("drain_opcnt", op_count, 16'd6);
`else
        check("drain_opcnt", op_count, 16'd0);
`endif

        // Push attempt while full and draining, then push/pop at count 3.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end
        check("full_pop_pre_count", count, 4);
        check("full_pop_in_ready", in_ready, 0);
        cycle(1'b1, 3'd5, 8'h12, 8'h34, 1'b1);
        check("full_pop_count", count, 3);
        cycle(1'b1, 3'd6, 8'h56, 8'h78, 1'b1);
        check("push_pop_count", count, 3);
        repeat (8) cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);

        // Throughput and pointer wrap: 20 back-to-back.
        do_reset();
        for (int t = 0; t < 24; t++) begin
            if (t >= 3 && t <= 22) begin
                check("tp_valid", out_valid, 1);
                check("tp_F", out_F, ta[t-3] ^ tb[t-3]);
            end
            if (t < 20) begin
                ta[t] = 8'($urandom);
                tb[t] = 8'($urandom);
                cycle(1'b1, 3'(t), ta[t], tb[t], 1'b1);
            end else begin
                cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
            end
        end

        // Random traffic.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, 3'($urandom),
                  8'($urandom), 8'($urandom),
                  ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
        end
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
